rng_nibble_feeder: RTL and testbench

//  Upstream stage of the decoy generator in the clk240 domain.
//  - Pulls 32-bit random words from the RNG FIFO (standard FIFO, 1-cycle read latency).
//  - Slices each word into nibbles, LSB nibble first.
//  - Presents each nibble on rng_value, qualified by the periodic rd_en_4 strobe, aligned to the PPS edge.
//  - Reports FIFO underflow without ever breaking strobe cadence.

---
 rtl/rng_feeder_pkg.sv | 24 ++
 rtl/pps_edge_sync.sv | 30 +++
 rtl/rng_nibble_feeder.sv | 214 +++++++++++++++++++++
 tb/tb_rng_nibble_feeder.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rng_feeder_pkg.sv
// Shared types and constants for the RNG nibble feeder and its helpers.
// The LFSR constants are only referenced when RNG_LFSR_FALLBACK_EN is defined.
package rng_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_PPS = 2'd1,
        RUN      = 2'd2
    } feeder_state_e;

    localparam int WORD_W_DEFAULT = 32;
    localparam int NIB_W_DEFAULT  = 4;
    localparam int NIBS_PER_WORD  = WORD_W_DEFAULT / NIB_W_DEFAULT;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1 in right-shift form:
    // feedback is the XOR of bits 0, 2, 3 and 5, inserted at bit 15.
    localparam logic [15:0] LFSR_SEED    = 16'hACE1;
    localparam logic [15:0] LFSR_FB_MASK = 16'h002D;

    function automatic int nibs_per_word(input int word_w, input int nib_w);
        return word_w / nib_w;
    endfunction

endpackage

// File: rtl/pps_edge_sync.sv
// Two-flop synchroniser for an asynchronous PPS input followed by a
// registered rising-edge detector. rise is a single-cycle pulse that is high
// three clock cycles after async_in rises.
module pps_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic sync1;
    logic sync2;
    logic sync3;

    // Synchronise, keep one history bit and register the edge pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync1 <= async_in;
            sync2 <= sync1;
            sync3 <= sync2;
            rise  <= sync2 & ~sync3;
        end
    end

endmodule

// File: rtl/rng_nibble_feeder.sv
// RNG nibble feeder: pulls 32-bit words from the RNG FIFO, slices them LSB
// nibble first and presents one nibble per rd_en_4 strobe, aligned to PPS.
// Optional feature macro: RNG_LFSR_FALLBACK_EN (starved strobes output LFSR
// low bits instead of zero).
//
// Handshakes:
//  - FIFO side: fifo_rd_en is a one-cycle read pulse issued only when
//    !fifo_empty; the word is taken from fifo_dout on the following cycle.
//    At most one read is in flight and it only targets an empty slot.
//  - Consumer side: rd_en_4 is a one-cycle "valid" strobe with no ready;
//    rng_value is updated on the same cycle and held until the next strobe.
module rng_nibble_feeder
    import rng_feeder_pkg::*;
#(
    parameter int STROBE_DIV = 6,
    parameter int WORD_W     = 32,
    parameter int NIB_W      = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk240,
    input  logic              rst_240_n,
    input  logic              enable,
    input  logic              pps_trigger,
    input  logic              pps_i,
    input  logic [WORD_W-1:0] fifo_dout,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    output logic [NIB_W-1:0]  rng_value,
    output logic              rd_en_4,
    output logic              underflow,
    output logic [CNT_W-1:0]  underflow_cnt,
    output logic              run,
    output feeder_state_e     state
);

    localparam int NIBS  = nibs_per_word(WORD_W, NIB_W);
    localparam int IDX_W = (NIBS > 1) ? $clog2(NIBS) : 1;
    localparam int DIV_W = (STROBE_DIV > 1) ? $clog2(STROBE_DIV) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBS - 1);
    localparam logic [DIV_W-1:0] LAST_CNT = DIV_W'(STROBE_DIV - 1);

    feeder_state_e    state_q;
    feeder_state_e    state_d;
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic             strobe_d;
    logic             pps_rise;
    logic             arm;
    logic             flush;

    logic [WORD_W-1:0] act_word;
    logic [IDX_W-1:0]  act_idx;
    logic              act_valid;
    logic [WORD_W-1:0] pre_word;
    logic              pre_valid;
    logic              in_flight;
    logic              ret;
    logic [NIB_W-1:0]  fallback;

    pps_edge_sync u_pps_sync (
        .clk      (clk240),
        .rst_n    (rst_240_n),
        .async_in (pps_i),
        .rise     (pps_rise)
    );

    assign arm   = enable && pps_trigger;
    assign flush = (state_d == IDLE);
    assign ret   = in_flight;

    // Prefetch whenever armed-or-running and the single prefetch slot is free.
    assign fifo_rd_en = (state_q != IDLE) && !pre_valid && !in_flight && !fifo_empty;

    assign run   = (state_q == RUN);
    assign state = state_q;

`ifdef RNG_LFSR_FALLBACK_EN
    logic [15:0] lfsr_q;

    // LFSR steps once per strobe, whether or not a real nibble was available.
    always_ff @(posedge clk240 or negedge rst_240_n) begin
        if (!rst_240_n) begin
            lfsr_q <= LFSR_SEED;
        end else if (strobe_d) begin
            lfsr_q <= {^(lfsr_q & LFSR_FB_MASK), lfsr_q[15:1]};
        end
    end

    assign fallback = lfsr_q[NIB_W-1:0];
`else
    assign fallback = '0;
`endif

    // State and strobe-phase counter registers.
    always_ff @(posedge clk240 or negedge rst_240_n) begin
        if (!rst_240_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, counter phase and strobe decision. A PPS edge in RUN only
    // restarts the phase, so a realign never produces an extra strobe.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        strobe_d = 1'b0;
        if (!arm) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = WAIT_PPS;
                    cnt_d   = '0;
                end
                WAIT_PPS: begin
                    if (pps_rise) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end
                end
                RUN: begin
                    if (pps_rise || (cnt_q == LAST_CNT)) begin
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + DIV_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        strobe_d = (state_d == RUN) && (cnt_d == LAST_CNT);
    end

    // Strobe output, nibble presentation and underflow bookkeeping.
    always_ff @(posedge clk240 or negedge rst_240_n) begin
        if (!rst_240_n) begin
            rd_en_4       <= 1'b0;
            rng_value     <= '0;
            underflow     <= 1'b0;
            underflow_cnt <= '0;
        end else begin
            rd_en_4 <= strobe_d;
            if (strobe_d) begin
                if (act_valid) begin
                    rng_value <= act_word[int'(act_idx)*NIB_W +: NIB_W];
                end else begin
                    rng_value <= fallback;
                    underflow <= 1'b1;
                    if (underflow_cnt != {CNT_W{1'b1}}) begin
                        underflow_cnt <= underflow_cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

    // Two-level word buffer. A returning word goes to the active slot when it
    // is exhausted (including the cycle its last nibble is consumed), else to
    // prefetch. Dropping to IDLE discards both slots.
    always_ff @(posedge clk240 or negedge rst_240_n) begin
        if (!rst_240_n) begin
            act_word  <= '0;
            act_idx   <= '0;
            act_valid <= 1'b0;
            pre_word  <= '0;
            pre_valid <= 1'b0;
            in_flight <= 1'b0;
        end else begin
            in_flight <= fifo_rd_en;
            if (flush) begin
                act_idx   <= '0;
                act_valid <= 1'b0;
                pre_valid <= 1'b0;
            end else if (strobe_d && act_valid) begin
                if (act_idx == LAST_IDX) begin
                    act_idx <= '0;
                    if (pre_valid) begin
                        act_word  <= pre_word;
                        pre_valid <= 1'b0;
                    end else if (ret) begin
                        act_word <= fifo_dout;
                    end else begin
                        act_valid <= 1'b0;
                    end
                end else begin
                    act_idx <= act_idx + IDX_W'(1);
                    if (ret) begin
                        pre_word  <= fifo_dout;
                        pre_valid <= 1'b1;
                    end
                end
            end else if (ret) begin
                if (!act_valid) begin
                    act_word  <= fifo_dout;
                    act_idx   <= '0;
                    act_valid <= 1'b1;
                end else begin
                    pre_word  <= fifo_dout;
                    pre_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rng_nibble_feeder.sv
// Directed self-checking bench for rng_nibble_feeder: nominal slicing and
// cadence, starvation, reset mid-run, PPS realign, disarm/re-arm and (when
// RNG_LFSR_FALLBACK_EN is defined) the LFSR fallback values.
module tb_rng_nibble_feeder;
    import rng_feeder_pkg::*;

    logic          clk240 = 1'b0;
    logic          rst_240_n;
    logic          enable;
    logic          pps_trigger;
    logic          pps_i;
    logic [31:0]   fifo_dout = 32'h0;
    logic          fifo_empty = 1'b1;
    logic          fifo_rd_en;
    logic [3:0]    rng_value;
    logic          rd_en_4;
    logic          underflow;
    logic [15:0]   underflow_cnt;
    logic          run;
    feeder_state_e state;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0] fifo_q[$];
    logic        rd_seen = 1'b0;

    rng_nibble_feeder #(
        .STROBE_DIV (6),
        .WORD_W     (32),
        .NIB_W      (4),
        .CNT_W      (16)
    ) dut (
        .clk240        (clk240),
        .rst_240_n     (rst_240_n),
        .enable        (enable),
        .pps_trigger   (pps_trigger),
        .pps_i         (pps_i),
        .fifo_dout     (fifo_dout),
        .fifo_empty    (fifo_empty),
        .fifo_rd_en    (fifo_rd_en),
        .rng_value     (rng_value),
        .rd_en_4       (rd_en_4),
        .underflow     (underflow),
        .underflow_cnt (underflow_cnt),
        .run           (run),
        .state         (state)
    );

    // Clock and cycle counter (cyc == N between edge N and edge N+1).
    always #5 clk240 = ~clk240;
    always @(posedge clk240) cyc++;

    // FIFO model: read request seen mid-cycle, data presented just after the edge.
    always @(negedge clk240) rd_seen = fifo_rd_en;
    always @(posedge clk240) begin
        #1;
        if (rd_seen && fifo_q.size() > 0) fifo_dout = fifo_q.pop_front();
        fifo_empty = (fifo_q.size() == 0);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_strobe(input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk240);
            if (rd_en_4) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk240);
        rst_240_n   = 1'b0;
        enable      = 1'b0;
        pps_trigger = 1'b0;
        pps_i       = 1'b0;
        fifo_q.delete();
        repeat (3) @(negedge clk240);
        rst_240_n = 1'b1;
    endtask

    // Arm, let prefetch settle, then raise pps_i for two cycles; returns the pps_i rise cycle.
    task automatic arm_and_pps(output int p);
        @(negedge clk240);
        enable      = 1'b1;
        pps_trigger = 1'b1;
        repeat (8) @(negedge clk240);
        pps_i = 1'b1;
        p     = cyc;
        repeat (2) @(negedge clk240);
        pps_i = 1'b0;
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic fb;
        fb = v[0] ^ v[2] ^ v[3] ^ v[5];
        return {fb, v[15:1]};
    endfunction

    initial begin
        int p;
        int s;
        int at;
        int prev;
        logic [31:0] w;
        logic seen;

        rst_240_n   = 1'b0;
        enable      = 1'b0;
        pps_trigger = 1'b0;
        pps_i       = 1'b0;

        // Reset state.
        do_reset();
        @(negedge clk240);
        check_eq("reset_rng_value", 32'(rng_value), 32'h0);
        check_eq("reset_rd_en_4", 32'(rd_en_4), 32'h0);
        check_eq("reset_run", 32'(run), 32'h0);
        check_eq("reset_underflow_cnt", 32'(underflow_cnt), 32'h0);
        check_eq("reset_state", 32'(state), 32'(IDLE));

        // Nominal: two words give nibbles 0..F every 6 cycles, first at pps+9.
        do_reset();
        fifo_q.push_back(32'h76543210);
        fifo_q.push_back(32'hFEDCBA98);
        arm_and_pps(p);
        check_eq("nom_wait_run", 32'(run), 32'h0);
        prev = p + 3;
        for (int i = 0; i < 16; i++) begin
            wait_strobe(12, at);
            check_eq($sformatf("nom_time_%0d", i), 32'(at), 32'(prev + 6));
            check_eq($sformatf("nom_nib_%0d", i), 32'(rng_value), 32'(i));
            prev = prev + 6;
        end
        pps_trigger = 1'b0;
        @(negedge clk240);
        check_eq("nom_disarm_state", 32'(state), 32'(IDLE));
        check_eq("nom_disarm_rd_en_4", 32'(rd_en_4), 32'h0);
        check_eq("nom_hold_value", 32'(rng_value), 32'hF);
        check_eq("nom_no_underflow", 32'(underflow), 32'h0);

        // Starvation: one word, then the 9th strobe is starved.
        do_reset();
        w = 32'h89ABCDEF;
        fifo_q.push_back(w);
        arm_and_pps(p);
        prev = p + 3;
        for (int i = 0; i < 8; i++) begin
            wait_strobe(12, at);
            check_eq($sformatf("starve_time_%0d", i), 32'(at), 32'(prev + 6));
            check_eq($sformatf("starve_nib_%0d", i), 32'(rng_value), 32'((w >> (4 * i)) & 32'hF));
            prev = prev + 6;
        end
        check_eq("starve_pre_underflow", 32'(underflow), 32'h0);
        wait_strobe(12, at);
        check_eq("starve_9_time", 32'(at), 32'(prev + 6));
        check_eq("starve_9_value", 32'(rng_value), 32'h0);
        check_eq("starve_9_underflow", 32'(underflow), 32'h1);
        check_eq("starve_9_cnt", 32'(underflow_cnt), 32'h1);
        prev = prev + 6;
        wait_strobe(12, at);
        check_eq("starve_10_time", 32'(at), 32'(prev + 6));
        check_eq("starve_10_cnt", 32'(underflow_cnt), 32'h2);

        // Reset mid-run: outputs clear immediately, no reads until re-armed.
        repeat (2) @(negedge clk240);
        rst_240_n = 1'b0;
        #1;
        check_eq("rst_run", 32'(run), 32'h0);
        check_eq("rst_rng_value", 32'(rng_value), 32'h0);
        check_eq("rst_underflow", 32'(underflow), 32'h0);
        check_eq("rst_underflow_cnt", 32'(underflow_cnt), 32'h0);
        check_eq("rst_rd_en_4", 32'(rd_en_4), 32'h0);
        check_eq("rst_fifo_rd_en", 32'(fifo_rd_en), 32'h0);
        pps_trigger = 1'b0;
        fifo_q.push_back(32'h11111111);
        repeat (2) @(negedge clk240);
        rst_240_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk240);
            seen = seen | fifo_rd_en;
        end
        check_eq("rst_no_read_unarmed", 32'(seen), 32'h0);
        pps_trigger = 1'b1;
        repeat (6) @(negedge clk240);
        check_eq("rst_rearm_reads", 32'(fifo_q.size()), 32'h0);

        // Realign: second PPS edge lands when cnt==3.
        do_reset();
        fifo_q.push_back(32'h76543210);
        arm_and_pps(p);
        wait_strobe(12, s);
        check_eq("realign_first_time", 32'(s), 32'(p + 9));
        check_eq("realign_first_nib", 32'(rng_value), 32'h0);
        @(negedge clk240);
        pps_i = 1'b1;
        repeat (2) @(negedge clk240);
        pps_i = 1'b0;
        wait_strobe(14, at);
        check_eq("realign_second_time", 32'(at), 32'(s + 10));
        check_eq("realign_second_nib", 32'(rng_value), 32'h1);
        wait_strobe(12, at);
        check_eq("realign_third_time", 32'(at), 32'(s + 16));
        check_eq("realign_third_nib", 32'(rng_value), 32'h2);

        // Disarm after three nibbles, then re-arm onto a fresh word.
        do_reset();
        fifo_q.push_back(32'h87654321);
        fifo_q.push_back(32'h0FEDCBA9);
        fifo_q.push_back(32'hCCCCCCC6);
        arm_and_pps(p);
        for (int i = 0; i < 3; i++) begin
            wait_strobe(12, at);
            check_eq($sformatf("disarm_nib_%0d", i), 32'(rng_value), 32'(i + 1));
        end
        pps_trigger = 1'b0;
        @(negedge clk240);
        check_eq("disarm_state", 32'(state), 32'(IDLE));
        check_eq("disarm_rd_en_4", 32'(rd_en_4), 32'h0);
        check_eq("disarm_hold_value", 32'(rng_value), 32'h3);
        repeat (4) @(negedge clk240);
        check_eq("disarm_fifo_untouched", 32'(fifo_q.size()), 32'h1);
        arm_and_pps(p);
        check_eq("rearm_fifo_drained", 32'(fifo_q.size()), 32'h0);
        wait_strobe(12, at);
        check_eq("rearm_first_time", 32'(at), 32'(p + 9));
        check_eq("rearm_first_nib", 32'(rng_value), 32'h6);
        wait_strobe(12, at);
        check_eq("rearm_second_nib", 32'(rng_value), 32'hC);

`ifdef RNG_LFSR_FALLBACK_EN
        // LFSR fallback with an empty FIFO from the start.
        begin
            logic [15:0] l;
            do_reset();
            arm_and_pps(p);
            l = 16'hACE1;
            for (int i = 0; i < 6; i++) begin
                wait_strobe(12, at);
                check_eq($sformatf("lfsr_nib_%0d", i), 32'(rng_value), 32'(l[3:0]));
                check_eq($sformatf("lfsr_cnt_%0d", i), 32'(underflow_cnt), 32'(i + 1));
                l = lfsr_step(l);
            end
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
